alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_pipe_dec.sv | 39 +++
 rtl/alu_pipe.sv | 151 +++++++++++++++
 tb/tb_alu_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control encodings and operand-A select constants for the ALU pipeline.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1111
    } alu_ctl_t;

    localparam logic [1:0] SEL_WB   = 2'b00;
    localparam logic [1:0] SEL_IMEM = 2'b01;
    localparam logic [1:0] SEL_DATA = 2'b10;
    localparam logic [1:0] SEL_BAD  = 2'b11;

endpackage

// File: rtl/alu_pipe_dec.sv
// Combinational ALU decoder: {opb5, funct7b5, funct3, ALUOp} -> ALU control.
module alu_pipe_dec
    import alu_pkg::*;
(
    input  logic [6:0] ins,
    output alu_ctl_t   ctl
);

    logic       opb5;
    logic       funct7b5;
    logic [2:0] funct3;
    logic [1:0] alu_op;

    assign opb5     = ins[6];
    assign funct7b5 = ins[5];
    assign funct3   = ins[4:2];
    assign alu_op   = ins[1:0];

    always_comb begin
        ctl = ALU_ADD;
        if (alu_op == 2'b00) begin
            ctl = ALU_ADD;
        end else if (alu_op == 2'b01) begin
            ctl = ALU_SUB;
        end else begin
            case (funct3)
                3'b000:  ctl = (funct7b5 && opb5) ? ALU_SUB : ALU_ADD;
                3'b001:  ctl = ALU_SLL;
                3'b010:  ctl = ALU_SLT;
                3'b011:  ctl = ALU_SLTU;
                3'b100:  ctl = ALU_XOR;
                3'b101:  ctl = funct7b5 ? ALU_SRA : ALU_SRL;
                3'b110:  ctl = ALU_OR;
                default: ctl = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU: S1 selects operand A and decodes, S2 holds result and flags.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_ins,
    input  logic [WIDTH-1:0] in_d0,
    input  logic [WIDTH-1:0] in_d1,
    input  logic [WIDTH-1:0] in_d2,
    input  logic [WIDTH-1:0] in_srcb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_sign,
    output logic             out_overflow,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int SHW = $clog2(WIDTH);

    logic [1:0]       sel;
    logic [WIDTH-1:0] srca;
    alu_ctl_t         dec_ctl;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    alu_ctl_t         s1_ctl;
    logic             s1_illegal;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic             s2_zero;
    logic             s2_sign;
    logic             s2_ovf;
    logic             s2_illegal;
    logic [CNT_W-1:0] cnt;

    logic             s2_load;
    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] ex_result;
    logic             ex_ovf;

    assign sel = in_ins[8:7];

    alu_pipe_dec u_dec (
        .ins (in_ins[6:0]),
        .ctl (dec_ctl)
    );

    always_comb begin
        srca = in_d2;
        case (sel)
            SEL_WB:   srca = in_d0;
            SEL_IMEM: srca = in_d1;
            default:  srca = in_d2;
        endcase
    end

    // S2 may take a new entry when empty or draining; S1 follows S2.
    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;

    // Subtract shares the adder via inverted B plus carry-in; overflow test uses the effective B.
    assign is_sub  = (s1_ctl == ALU_SUB);
    assign b_op    = is_sub ? ~s1_b : s1_b;
    assign sum     = s1_a + b_op + {{(WIDTH-1){1'b0}}, is_sub};
    assign add_ovf = (s1_a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != s1_a[WIDTH-1]);
    assign shamt   = s1_b[SHW-1:0];

    always_comb begin
        ex_result = '0;
        ex_ovf    = 1'b0;
        case (s1_ctl)
            ALU_ADD, ALU_SUB: begin
                ex_result = sum;
                ex_ovf    = add_ovf;
            end
            ALU_AND:  ex_result = s1_a & s1_b;
            ALU_OR:   ex_result = s1_a | s1_b;
            ALU_XOR:  ex_result = s1_a ^ s1_b;
            ALU_SLL:  ex_result = s1_a << shamt;
            ALU_SRL:  ex_result = s1_a >> shamt;
            ALU_SRA:  ex_result = $signed(s1_a) >>> shamt;
            ALU_SLT:  ex_result = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            ALU_SLTU: ex_result = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
            default:  ex_result = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_ctl     <= ALU_ADD;
            s1_illegal <= 1'b0;
            s2_valid   <= 1'b0;
            s2_result  <= '0;
            s2_zero    <= 1'b0;
            s2_sign    <= 1'b0;
            s2_ovf     <= 1'b0;
            s2_illegal <= 1'b0;
            cnt        <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a       <= srca;
                    s1_b       <= in_srcb;
                    s1_ctl     <= dec_ctl;
                    s1_illegal <= (sel == SEL_BAD);
                end
            end
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_result  <= ex_result;
                    s2_zero    <= (ex_result == '0);
                    s2_sign    <= ex_result[WIDTH-1];
                    s2_ovf     <= ex_ovf;
                    s2_illegal <= s1_illegal;
                end
            end
            if (s2_valid && out_ready && s2_ovf && (cnt != '1)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid    = s2_valid;
    assign out_result   = s2_result;
    assign out_zero     = s2_zero;
    assign out_sign     = s2_sign;
    assign out_overflow = s2_ovf;
    assign out_illegal  = s2_illegal;
    assign ovf_count    = cnt;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: a default instance plus a CNT_W=2 instance sharing stimulus.
module tb_alu_pipe;
    import alu_pkg::*;

    localparam logic [8:0] I_ADD  = 9'b00_0_0_000_00;
    localparam logic [8:0] I_SUB  = 9'b00_0_0_000_01;
    localparam logic [8:0] I_RSUB = 9'b00_1_1_000_10;
    localparam logic [8:0] I_RADD = 9'b00_0_1_000_10;
    localparam logic [8:0] I_SLL  = 9'b00_0_0_001_10;
    localparam logic [8:0] I_SLT  = 9'b00_0_0_010_10;
    localparam logic [8:0] I_SLTU = 9'b00_0_0_011_10;
    localparam logic [8:0] I_XOR  = 9'b00_0_0_100_10;
    localparam logic [8:0] I_SRL  = 9'b00_0_0_101_10;
    localparam logic [8:0] I_SRA  = 9'b00_0_1_101_10;
    localparam logic [8:0] I_OR   = 9'b00_0_0_110_10;
    localparam logic [8:0] I_AND  = 9'b00_0_0_111_10;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [8:0]  in_ins;
    logic [31:0] in_d0, in_d1, in_d2, in_srcb;
    logic        out_ready;

    logic        in_ready, out_valid, out_zero, out_sign, out_overflow, out_illegal;
    logic [31:0] out_result;
    logic [7:0]  ovf_count;

    logic        c2_in_ready, c2_out_valid, c2_out_zero, c2_out_sign, c2_out_overflow, c2_out_illegal;
    logic [31:0] c2_out_result;
    logic [1:0]  c2_ovf_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
        .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_srcb(in_srcb),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_sign(out_sign), .out_overflow(out_overflow),
        .out_illegal(out_illegal), .ovf_count(ovf_count)
    );

    alu_pipe #(.WIDTH(32), .CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c2_in_ready), .in_ins(in_ins),
        .in_d0(in_d0), .in_d1(in_d1), .in_d2(in_d2), .in_srcb(in_srcb),
        .out_valid(c2_out_valid), .out_ready(out_ready), .out_result(c2_out_result),
        .out_zero(c2_out_zero), .out_sign(c2_out_sign), .out_overflow(c2_out_overflow),
        .out_illegal(c2_out_illegal), .ovf_count(c2_ovf_count)
    );

    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> (out_valid && $stable(out_result) && $stable(out_overflow)))
        else $error("FAIL sva_out_stable");

    a_add_no_ovf: assert property (@(posedge clk) disable iff (reset)
        (dut.s1_valid && dut.s2_load && dut.s1_ctl == ALU_ADD && (dut.s1_a[31] != dut.s1_b[31]))
        |=> !out_overflow)
        else $error("FAIL sva_add_no_ovf");

    a_sel_illegal: assert property (@(posedge clk) disable iff (reset)
        (in_valid && in_ready) |=> (dut.s1_illegal == !$onehot0($past(in_ins[8:7]))))
        else $error("FAIL sva_sel_illegal");

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, then wait until it sits in S2 (outputs valid); next edge consumes it.
    task automatic exec(input logic [8:0] ins, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] a2, input logic [31:0] b);
        in_valid = 1'b1;
        in_ins   = ins;
        in_d0    = a0;
        in_d1    = a1;
        in_d2    = a2;
        in_srcb  = b;
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", out_result); end
        n_checks++; if ({out_zero, out_sign, out_overflow, out_illegal} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {out_zero, out_sign, out_overflow, out_illegal}); end
        n_checks++; if (ovf_count !== 8'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", ovf_count); end
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tick();
    endtask

    task automatic test_add_ovf();
        in_valid = 1'b1; in_ins = I_ADD; in_d0 = 32'h7FFF_FFFF; in_d1 = '0; in_d2 = '0; in_srcb = 32'h1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b expected 0", out_valid); end
        tick();
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_result !== 32'h8000_0000) begin n_fail++; $display("FAIL add_ovf_result: got %h expected 80000000", out_result); end
        n_checks++; if ({out_overflow, out_sign, out_zero} !== 3'b110) begin n_fail++; $display("FAIL add_ovf_flags: got %b expected 110", {out_overflow, out_sign, out_zero}); end
        n_checks++; if (ovf_count !== 8'd0) begin n_fail++; $display("FAIL cnt_before_hs: got %0d expected 0", ovf_count); end
        tick();
        n_checks++; if (ovf_count !== 8'd1) begin n_fail++; $display("FAIL cnt_after_hs: got %0d expected 1", ovf_count); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_arith_cmp();
        exec(I_SUB, 32'd5, '0, '0, 32'd5);
        n_checks++; if (out_result !== 32'h0) begin n_fail++; $display("FAIL sub_result: got %h expected 0", out_result); end
        n_checks++; if ({out_zero, out_overflow, out_sign} !== 3'b100) begin n_fail++; $display("FAIL sub_flags: got %b expected 100", {out_zero, out_overflow, out_sign}); end
        exec(I_SLT, 32'hFFFF_FFFF, '0, '0, 32'd1);
        n_checks++; if (out_result !== 32'd1) begin n_fail++; $display("FAIL slt: got %h expected 1", out_result); end
        exec(I_SLTU, 32'hFFFF_FFFF, '0, '0, 32'd1);
        n_checks++; if (out_result !== 32'd0 || out_zero !== 1'b1) begin n_fail++; $display("FAIL sltu: got %h/%b expected 0/1", out_result, out_zero); end
        exec(I_RSUB, 32'd3, '0, '0, 32'd5);
        n_checks++; if (out_result !== 32'hFFFF_FFFE || out_sign !== 1'b1) begin n_fail++; $display("FAIL rsub: got %h/%b expected fffffffe/1", out_result, out_sign); end
        exec(I_RADD, 32'd3, '0, '0, 32'd5);
        n_checks++; if (out_result !== 32'd8) begin n_fail++; $display("FAIL radd_f7_only: got %h expected 8", out_result); end
        exec(I_SUB, 32'h8000_0000, '0, '0, 32'd1);
        n_checks++; if (out_result !== 32'h7FFF_FFFF || out_overflow !== 1'b1) begin n_fail++; $display("FAIL sub_ovf: got %h/%b expected 7fffffff/1", out_result, out_overflow); end
        exec(I_ADD, 32'hFFFF_FFFF, '0, '0, 32'd1);
        n_checks++; if (out_result !== 32'd0 || {out_zero, out_overflow} !== 2'b10) begin n_fail++; $display("FAIL add_wrap: got %h/%b expected 0/10", out_result, {out_zero, out_overflow}); end
        tick();
        n_checks++; if (ovf_count !== 8'd2) begin n_fail++; $display("FAIL cnt_arith: got %0d expected 2", ovf_count); end
    endtask

    task automatic test_logic_shift();
        exec(I_SRA, 32'h8000_0000, '0, '0, 32'h21);
        n_checks++; if (out_result !== 32'hC000_0000) begin n_fail++; $display("FAIL sra: got %h expected c0000000", out_result); end
        exec(I_SRL, 32'h8000_0000, '0, '0, 32'h21);
        n_checks++; if (out_result !== 32'h4000_0000) begin n_fail++; $display("FAIL srl: got %h expected 40000000", out_result); end
        exec(I_SLL, 32'h1, '0, '0, 32'h3F);
        n_checks++; if (out_result !== 32'h8000_0000 || out_overflow !== 1'b0) begin n_fail++; $display("FAIL sll: got %h/%b expected 80000000/0", out_result, out_overflow); end
        exec(I_XOR, 32'hF0F0_F0F0, '0, '0, 32'hFF00_FF00);
        n_checks++; if (out_result !== 32'h0FF0_0FF0) begin n_fail++; $display("FAIL xor: got %h expected 0ff00ff0", out_result); end
        exec(I_OR, 32'hF0F0_F0F0, '0, '0, 32'hFF00_FF00);
        n_checks++; if (out_result !== 32'hFFF0_FFF0) begin n_fail++; $display("FAIL or: got %h expected fff0fff0", out_result); end
        exec(I_AND, 32'hF0F0_F0F0, '0, '0, 32'hFF00_FF00);
        n_checks++; if (out_result !== 32'hF000_F000) begin n_fail++; $display("FAIL and: got %h expected f000f000", out_result); end
        tick();
    endtask

    task automatic test_select();
        exec({2'b01, 7'b0}, 32'h5, 32'h11, 32'h22, 32'h0);
        n_checks++; if (out_result !== 32'h11 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL sel01: got %h/%b expected 11/0", out_result, out_illegal); end
        exec({2'b10, 7'b0}, 32'h5, 32'h11, 32'h22, 32'h0);
        n_checks++; if (out_result !== 32'h22 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL sel10: got %h/%b expected 22/0", out_result, out_illegal); end
        exec({2'b11, 7'b0}, 32'h5, 32'h11, 32'hAA, 32'h0);
        n_checks++; if (out_result !== 32'hAA || out_illegal !== 1'b1) begin n_fail++; $display("FAIL sel11: got %h/%b expected aa/1", out_result, out_illegal); end
        exec({2'b00, 7'b0}, 32'h5, 32'h11, 32'hAA, 32'h0);
        n_checks++; if (out_result !== 32'h5 || out_illegal !== 1'b0) begin n_fail++; $display("FAIL sel00: got %h/%b expected 5/0", out_result, out_illegal); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q [4];
        int  acc = 0;
        int  dlv = 0;
        int  stall = -1;
        bit  saw_both = 1'b0;
        bit  acc_now, dlv_now;
        exp_q = '{32'd11, 32'd21, 32'd31, 32'd41};
        for (int cyc = 0; cyc < 30 && dlv < 4; cyc++) begin
            if (out_valid && stall < 0) stall = 3;
            out_ready = (stall > 0) ? 1'b0 : 1'b1;
            in_valid  = (acc < 4);
            in_ins    = I_ADD;
            in_d0     = 32'(10 * (acc + 1));
            in_srcb   = 32'd1;
            #1;
            if (stall > 0) begin
                n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_in_ready: got %b expected 0", in_ready); end
                n_checks++; if (out_valid !== 1'b1 || out_result !== exp_q[dlv]) begin n_fail++; $display("FAIL b2b_stall_hold: got %b/%h expected 1/%h", out_valid, out_result, exp_q[dlv]); end
            end
            acc_now = in_valid && in_ready;
            dlv_now = out_valid && out_ready;
            if (dlv_now) begin
                n_checks++; if (out_result !== exp_q[dlv]) begin n_fail++; $display("FAIL b2b_order: got %h expected %h", out_result, exp_q[dlv]); end
                dlv++;
            end
            if (acc_now) acc++;
            if (acc_now && dlv_now) saw_both = 1'b1;
            if (stall > 0) stall--;
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++; if (dlv != 4) begin n_fail++; $display("FAIL b2b_delivered: got %0d expected 4", dlv); end
        n_checks++; if (acc != 4) begin n_fail++; $display("FAIL b2b_accepted: got %0d expected 4", acc); end
        n_checks++; if (saw_both !== 1'b1) begin n_fail++; $display("FAIL b2b_dual_handshake: got %b expected 1", saw_both); end
        tick();
    endtask

    task automatic test_reset_flight();
        bit leaked = 1'b0;
        in_valid = 1'b1; in_ins = I_ADD; in_d0 = 32'd1; in_srcb = 32'd1;
        tick();
        in_d0 = 32'd2;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0 || out_result !== 32'h0) begin n_fail++; $display("FAIL flight_reset_out: got %b/%h expected 0/0", out_valid, out_result); end
        n_checks++; if (ovf_count !== 8'd0 || c2_ovf_count !== 2'd0) begin n_fail++; $display("FAIL flight_reset_cnt: got %0d/%0d expected 0/0", ovf_count, c2_ovf_count); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flight_in_ready: got %b expected 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid !== 1'b0) leaked = 1'b1;
        end
        n_checks++; if (leaked !== 1'b0) begin n_fail++; $display("FAIL flight_no_delivery: got %b expected 0", leaked); end
    endtask

    task automatic test_ovf_sat();
        logic [1:0] exp_c2 [5];
        exp_c2 = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            exec(I_ADD, 32'h7FFF_FFFF, '0, '0, 32'd1);
            tick();
            n_checks++; if (c2_ovf_count !== exp_c2[i]) begin n_fail++; $display("FAIL sat_cnt%0d: got %0d expected %0d", i, c2_ovf_count, exp_c2[i]); end
        end
        n_checks++; if (ovf_count !== 8'd5) begin n_fail++; $display("FAIL wide_cnt: got %0d expected 5", ovf_count); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_ins = '0;
        in_d0 = '0; in_d1 = '0; in_d2 = '0; in_srcb = '0; out_ready = 1'b1;
        test_reset();
        test_add_ovf();
        test_arith_cmp();
        test_logic_shift();
        test_select();
        test_back_to_back();
        test_reset_flight();
        test_ovf_sat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
